imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the MIPS instruction memory from a byte stream, the writing end of the instruction-memory port the pipeline's fetch stage reads. It assembles incoming bytes into 32-bit instruction words and issues word writes at sequential byte addresses. It holds the pipeline in reset while loading and releases it once a halt word has been written.

## Interface

Parameters:
- ADDR_WIDTH, 8: instruction memory depth in words is 2^ADDR_WIDTH.
- HALT_WORD, 32'hFFFFFFFF: terminating instruction. It is written to memory, then the load ends.

Ports:
- Clock  input  1  system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high.
- Start  input  1  one-cycle pulse; begins a load from word address 0.
- RxData  input  8  incoming byte.
- RxValid  input  1  one-cycle strobe, one byte per strobe.
- IMemWrite  output  1  write enable to instruction memory, one cycle per word.
- IMemAddr  output  32  byte address (word index × 4; bits 1:0 always 0).
- IMemData  output  32  instruction word.
- CpuReset  output  1  holds the pipeline in reset; low only in DONE.
- Done  output  1  load complete, program valid.
- Error  output  1  load failed.
- WordCount  output  ADDR_WIDTH+1  words written in the current or last load, including the halt word.

## Operation

- States: IDLE, RECV, WRITE, CHECK (only with the macro), DONE, ERR.
- IDLE: waits for Start. Start moves to RECV and clears the byte counter, word address, WordCount and checksum.
- RECV: each RxValid shifts the byte in big-endian order: word <= {word[23:0], RxData}. The 4th byte moves to WRITE.
- WRITE lasts one cycle. It asserts IMemWrite with IMemAddr = word index × 4 and IMemData = the assembled word, then increments WordCount.
  - If the word equals HALT_WORD, go to CHECK (with macro) or DONE (without).
  - Else, if the word index was 2^ADDR_WIDTH−1, go to ERR (overflow, no halt word).
  - Else, increment the word index and return to RECV.
- An RxValid that arrives during the WRITE cycle is captured as byte 1 of the next word. No byte is lost.
- DONE: CpuReset=0, Done=1. Start re-enters RECV, reasserts CpuReset and clears Done.
- ERR: CpuReset=1, Error=1. Start re-enters RECV and clears Error.
- Start is ignored in RECV, WRITE and CHECK.
- RxValid is ignored in IDLE, DONE and ERR.
- Reset outputs: CpuReset=1; IMemWrite, IMemAddr, IMemData, Done, Error and WordCount all 0; state IDLE.
- Reset asserted mid-load aborts immediately: no further writes, IDLE on the next cycle, and memory contents already written are left as they are.

## Timing

- All outputs are registered.
- The 4th-byte RxValid in cycle N produces IMemWrite in cycle N+1 (WRITE state).
- Halt word without the macro: Done=1 and CpuReset=0 in cycle N+2.
- Start in cycle N: state is RECV in cycle N+1, so an RxValid in N+1 is accepted.
- Back-to-back RxValid every cycle is supported with no stalls.
- IMemAddr and IMemData are stable only while IMemWrite=1.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) covers every byte received, including the halt word's bytes.
  - After the halt-word write the FSM enters CHECK and waits for one more byte.
  - If that byte equals the sum, go to DONE; otherwise go to ERR. In either case, Done or Error appears one cycle after that byte's RxValid.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no checksum logic.
  - The halt-word write goes directly to DONE.

## Test plan

- Reset, then Start, then bytes 20 08 00 05, FF FF FF FF back-to-back.
  - Writes addr 0 = 32'h20080005, then addr 4 = 32'hFFFFFFFF.
  - Done=1, CpuReset=0, WordCount=2.
  - With the macro, also send checksum byte 8'h29 → Done=1.
- Same stream with a wrong checksum byte 8'h00 (macro on) → Error=1, CpuReset=1, Done=0.
- ADDR_WIDTH=2, four non-halt words.
  - Writes at addresses 0, 4, 8, C.
  - Error=1 after the 4th write; no write at address 0x10.
- A byte strobed in the same cycle as the WRITE of word 0 becomes the MSB of word 1, confirmed by the second IMemData.
- Reset asserted after 6 bytes → no further IMemWrite, state IDLE, CpuReset=1, WordCount=0.
- A Start pulse during RECV is ignored and the word alignment is unchanged. After DONE, a new Start reloads from address 0 with CpuReset=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream.
// Bytes are packed big-endian into 32-bit words, written at sequential byte
// addresses, and the pipeline is held in reset until a halt word lands.
// Optional macro LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte
// that must match the sum of every loaded byte before the load is accepted.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [7:0]            RxData,
    input  logic                  RxValid,
    output logic                  IMemWrite,
    output logic [31:0]           IMemAddr,
    output logic [31:0]           IMemData,
    output logic                  CpuReset,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH:0]   WordCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           word_q, word_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic                  wr_q, wr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  chk_byte;
`endif

    // Next-state and registered-output computation for the load sequence.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        idx_d      = idx_q;
        wc_d       = wc_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        chk_byte   = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d    = S_RECV;
                    byte_cnt_d = 2'd0;
                    idx_d      = '0;
                    wc_d       = '0;
                    cpu_rst_d  = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end
            S_RECV: begin
                if (RxValid) begin
                    word_d = {word_q[23:0], RxData};
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + RxData;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Word complete: launch the write for the next cycle.
                        state_d    = S_WRITE;
                        byte_cnt_d = 2'd0;
                        wr_d       = 1'b1;
                        addr_d     = 32'(idx_q) << 2;
                        data_d     = {word_q[23:0], RxData};
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                wc_d = wc_q + 1'b1;
                if (word_q == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    // A byte arriving alongside the halt write is the checksum.
                    if (RxValid) chk_byte = 1'b1;
                    else         state_d  = S_CHECK;
`else
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
`endif
                end else if (idx_q == IDX_MAX) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RECV;
                    // A byte strobed during the write starts the next word.
                    if (RxValid) begin
                        word_d     = {word_q[23:0], RxData};
                        byte_cnt_d = 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_d      = sum_q + RxData;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (RxValid) chk_byte = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (chk_byte) begin
            if (RxData == sum_q) begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                cpu_rst_d = 1'b0;
            end else begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            idx_q      <= '0;
            wc_q       <= '0;
            wr_q       <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            wc_q       <= wc_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign IMemWrite = wr_q;
    assign IMemAddr  = addr_q;
    assign IMemData  = data_q;
    assign CpuReset  = cpu_rst_q;
    assign Done      = done_q;
    assign Error     = err_q;
    assign WordCount = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (4-word memory so overflow is reachable).
// A transaction-level model predicts every output each cycle; directed
// sequences add literal checks on the write log and status flags.
module tb_imem_loader;

    localparam int          AW    = 2;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;

    logic          Clock = 1'b0;
    logic          Reset, Start, RxValid;
    logic [7:0]    RxData;
    logic          IMemWrite, CpuReset, Done, Error;
    logic [31:0]   IMemAddr, IMemData;
    logic [AW:0]   WordCount;

    imem_loader #(.ADDR_WIDTH(AW), .HALT_WORD(HALT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .RxData(RxData),
        .RxValid(RxValid), .IMemWrite(IMemWrite), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .CpuReset(CpuReset), .Done(Done),
        .Error(Error), .WordCount(WordCount)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_LOAD, M_CHECK, M_DONE, M_ERR} mode_t;
    mode_t       mode = M_IDLE;
    bit          armed = 0, pend = 0, take, ad_chk = 0;
    int          nb = 0, words = 0, widx = 0;
    logic [31:0] acc = 0, pword = 0;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum = 0;
`endif
    logic        e_wr, e_done, e_err, e_crst;
    logic [31:0] e_addr, e_data;
    int          e_wc;

    task automatic finish_load(input bit ok);
        if (ok) begin mode = M_DONE; e_done = 1; e_crst = 0; end
        else    begin mode = M_ERR;  e_err  = 1; end
    endtask

    // Predict the outputs registered at this edge from the inputs held this cycle.
    always @(posedge Clock) begin
        if (Reset) begin
            mode = M_IDLE; pend = 0; nb = 0; words = 0; armed = 1; ad_chk = 1;
            e_wr = 0; e_addr = 0; e_data = 0; e_done = 0; e_err = 0; e_crst = 1; e_wc = 0;
        end else if (armed) begin
            take = 0; e_wr = 0; ad_chk = 0;
            if (pend) begin
                pend = 0; words++; e_wc = words;
                if (pword == HALT) begin
`ifdef LOADER_CHECKSUM_EN
                    if (RxValid) finish_load(RxData == sum);
                    else mode = M_CHECK;
`else
                    finish_load(1);
`endif
                end else if (widx == DEPTH - 1) finish_load(0);
                else begin widx++; take = 1; end
            end else if (mode == M_LOAD) take = 1;
`ifdef LOADER_CHECKSUM_EN
            else if (mode == M_CHECK) begin
                if (RxValid) finish_load(RxData == sum);
            end
`endif
            else if (Start) begin
                mode = M_LOAD; nb = 0; words = 0; widx = 0;
                e_wc = 0; e_done = 0; e_err = 0; e_crst = 1;
`ifdef LOADER_CHECKSUM_EN
                sum = 0;
`endif
            end
            if (take && RxValid) begin
                acc = {acc[23:0], RxData}; nb++;
`ifdef LOADER_CHECKSUM_EN
                sum = sum + RxData;
`endif
                if (nb == 4) begin
                    nb = 0; pend = 1; pword = acc;
                    e_wr = 1; e_addr = widx * 4; e_data = acc; ad_chk = 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [31:0] wlog_a[$], wlog_d[$];

    always @(negedge Clock) begin
        if (armed) begin
            chk("IMemWrite", 32'(IMemWrite), 32'(e_wr));
            chk("CpuReset",  32'(CpuReset),  32'(e_crst));
            chk("Done",      32'(Done),      32'(e_done));
            chk("Error",     32'(Error),     32'(e_err));
            chk("WordCount", 32'(WordCount), 32'(e_wc));
            if (ad_chk) begin
                chk("IMemAddr", IMemAddr, e_addr);
                chk("IMemData", IMemData, e_data);
            end
        end
        if (IMemWrite === 1'b1) begin
            wlog_a.push_back(IMemAddr);
            wlog_d.push_back(IMemData);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit s, input bit v, input logic [7:0] d);
        Start = s; RxValid = v; RxData = d;
        @(negedge Clock);
        Start = 0; RxValid = 0;
    endtask

    task automatic send(input logic [7:0] b[$]);
        foreach (b[i]) drive(0, 1, b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 8'h00);
    endtask

    task automatic clear_log();
        wlog_a.delete(); wlog_d.delete();
    endtask

    initial begin
        Reset = 1; Start = 0; RxValid = 0; RxData = 0;
        @(negedge Clock);
        idle(2);
        chk("rst CpuReset",  32'(CpuReset),  32'd1);
        chk("rst Done",      32'(Done),      32'd0);
        chk("rst Error",     32'(Error),     32'd0);
        chk("rst WordCount", 32'(WordCount), 32'd0);
        chk("rst IMemWrite", 32'(IMemWrite), 32'd0);
        chk("rst IMemAddr",  IMemAddr,       32'd0);
        Reset = 0;
        idle(1);

        // Basic load: one instruction plus halt, halt byte stream back-to-back.
        clear_log();
        drive(1, 0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        send('{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h29});
`else
        send('{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
`endif
        idle(3);
        chk("t1 writes", wlog_a.size(), 32'd2);
        if (wlog_a.size() == 2) begin
            chk("t1 addr0", wlog_a[0], 32'h0);
            chk("t1 data0", wlog_d[0], 32'h20080005);
            chk("t1 addr1", wlog_a[1], 32'h4);
            chk("t1 data1", wlog_d[1], 32'hFFFFFFFF);
        end
        chk("t1 Done",      32'(Done),      32'd1);
        chk("t1 CpuReset",  32'(CpuReset),  32'd0);
        chk("t1 WordCount", 32'(WordCount), 32'd2);
        chk("t1 model wc",  32'(e_wc),      32'd2);

`ifdef LOADER_CHECKSUM_EN
        // Same stream with a bad checksum byte.
        drive(1, 0, 8'h00);
        send('{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        idle(2);
        drive(0, 1, 8'h00);
        idle(1);
        chk("ck Error",    32'(Error),    32'd1);
        chk("ck CpuReset", 32'(CpuReset), 32'd1);
        chk("ck Done",     32'(Done),     32'd0);
`endif

        // Overflow: four non-halt words fill the 4-word memory.
        clear_log();
        drive(1, 0, 8'h00);
        chk("ov CpuReset on start", 32'(CpuReset), 32'd1);
        chk("ov Done cleared",      32'(Done),     32'd0);
        send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10});
        send('{8'h11, 8'h12, 8'h13, 8'h14});
        idle(3);
        chk("ov writes", wlog_a.size(), 32'd4);
        if (wlog_a.size() == 4) begin
            chk("ov addr2", wlog_a[2], 32'h8);
            chk("ov addr3", wlog_a[3], 32'hC);
            chk("ov data3", wlog_d[3], 32'h0D0E0F10);
        end
        chk("ov Error",    32'(Error),    32'd1);
        chk("ov CpuReset", 32'(CpuReset), 32'd1);

        // Byte strobed during WRITE of word 0 becomes MSB of word 1.
        clear_log();
        drive(1, 0, 8'h00);
        chk("bw Error cleared", 32'(Error), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        send('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h60});
`else
        send('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'hFF, 8'hFF, 8'hFF, 8'hFF});
`endif
        idle(3);
        if (wlog_d.size() >= 2) chk("bw data1", wlog_d[1], 32'h55667788);
        else chk("bw writes", wlog_d.size(), 32'd3);
        chk("bw Done", 32'(Done), 32'd1);

        // Reset after six bytes aborts the load.
        clear_log();
        drive(1, 0, 8'h00);
        send('{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6});
        Reset = 1;
        idle(1);
        Reset = 0;
        send('{8'hB1, 8'hB2, 8'hB3, 8'hB4});
        idle(2);
        chk("ra writes",    wlog_a.size(),    32'd1);
        chk("ra CpuReset",  32'(CpuReset),    32'd1);
        chk("ra WordCount", 32'(WordCount),   32'd0);
        chk("ra Done",      32'(Done),        32'd0);

        // Start pulse in the middle of a word is ignored.
        clear_log();
        drive(1, 0, 8'h00);
        send('{8'hAA, 8'hBB});
        drive(1, 0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        send('{8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0A});
`else
        send('{8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
`endif
        idle(3);
        if (wlog_d.size() >= 1) chk("sr data0", wlog_d[0], 32'hAABBCCDD);
        chk("sr Done", 32'(Done), 32'd1);

        // Reload after DONE starts again at address 0 with the CPU held.
        clear_log();
        drive(1, 0, 8'h00);
        chk("rl CpuReset", 32'(CpuReset), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        send('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC});
`else
        send('{8'hFF, 8'hFF, 8'hFF, 8'hFF});
`endif
        idle(3);
        if (wlog_a.size() >= 1) chk("rl addr0", wlog_a[0], 32'h0);
        else chk("rl writes", wlog_a.size(), 32'd1);
        chk("rl WordCount", 32'(WordCount), 32'd1);
        chk("rl Done",      32'(Done),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
